// File: rtl/dff_reg_arbiter_if.sv
// Request/grant bundle between lab clients and the shared-register arbiter.
// Clients drive req/we/wdata; the arbiter returns grant, ack and data.
interface dff_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       we;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       rdata;
  logic [WIDTH-1:0]       reg_q;
  logic                   busy;

  modport master (
    output req, we, wdata,
    input  gnt, ack, rdata, reg_q, busy
  );

  modport slave (
    input  req, we, wdata,
    output gnt, ack, rdata, reg_q, busy
  );
endinterface

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ clients.
// Sequence per access: IDLE (pick) -> ACCESS (read/write) -> ACK.
module dff_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  dff_reg_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [PW-1:0]    pick, rr_idx, win_nxt;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] wslice;

  // Scan from the far end back to ptr so the closest requester wins.
  always_comb begin
    pick   = ptr_q;
    rr_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      rr_idx = PW'((int'(ptr_q) + k) % N_REQ);
      if (bus.req[rr_idx]) pick = rr_idx;
    end
  end

  assign win_nxt = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
  assign wslice  = bus.wdata[win_q*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = ACCESS;
          win_d   = pick;
        end
      end
      ACCESS: begin
        if (bus.req[win_q]) begin
          state_d = ACK;
        end else begin
          state_d = IDLE;
          ptr_d   = win_nxt;
        end
      end
      ACK: begin
        state_d = IDLE;
        ptr_d   = win_nxt;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = '0;
    ack_d   = '0;
    data_d  = data_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) gnt_d = ONE << pick;
      end
      ACCESS: begin
        if (bus.req[win_q]) begin
          ack_d = ONE << win_q;
          if (bus.we[win_q]) data_d = wslice;
          rdata_d = data_d;
        end
      end
      default: ;
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.reg_q = data_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Self-checking bench for dff_reg_arbiter: directed scenarios plus
// randomized transactions against a transaction-level reference model.
module tb_dff_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  int         m_ptr;
  logic [7:0] m_reg;
  logic [7:0] m_rdata;

  dff_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  dff_reg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 4'b1111;
    bus.we = 4'b0000;
    bus.wdata = '0;
    step();
    step();
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL rst_ack got=%b exp=0000", bus.ack); end
    checks++; if (bus.reg_q !== 8'h00) begin failures++; $display("FAIL rst_reg got=%h exp=00", bus.reg_q); end
    checks++; if (bus.rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h exp=00", bus.rdata); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL rst_first_gnt got=%b exp=0001", bus.gnt); end
    bus.req = 4'b0000;
    step();
    checks++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin failures++; $display("FAIL rst_abort busy=%b ack=%b exp 0/0000", bus.busy, bus.ack); end
    m_ptr = 1; m_reg = 8'h00; m_rdata = 8'h00;
  endtask

  task automatic test_single_write();
    bus.req = 4'b0100;
    bus.we = 4'b0100;
    bus.wdata = 32'h00A5_0000;
    step();
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL wr_gnt got=%b exp=0100", bus.gnt); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", bus.busy); end
    step();
    checks++; if (bus.ack !== 4'b0100 || bus.gnt !== 4'b0000) begin failures++; $display("FAIL wr_ack ack=%b gnt=%b exp 0100/0000", bus.ack, bus.gnt); end
    checks++; if (bus.rdata !== 8'hA5) begin failures++; $display("FAIL wr_rdata got=%h exp=a5", bus.rdata); end
    checks++; if (bus.reg_q !== 8'hA5) begin failures++; $display("FAIL wr_reg got=%h exp=a5", bus.reg_q); end
    bus.req = 4'b0000;
    step();
    checks++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin failures++; $display("FAIL wr_done busy=%b ack=%b exp 0/0000", bus.busy, bus.ack); end
    m_ptr = 3; m_reg = 8'hA5; m_rdata = 8'hA5;
  endtask

  task automatic test_read_back();
    bus.req = 4'b0010;
    bus.we = 4'b0000;
    bus.wdata = 32'h0000_7700;
    step();
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL rd_gnt got=%b exp=0010", bus.gnt); end
    step();
    checks++; if (bus.ack !== 4'b0010) begin failures++; $display("FAIL rd_ack got=%b exp=0010", bus.ack); end
    checks++; if (bus.rdata !== 8'hA5 || bus.reg_q !== 8'hA5) begin failures++; $display("FAIL rd_data rdata=%h reg=%h exp a5/a5", bus.rdata, bus.reg_q); end
    bus.req = 4'b0000;
    step();
    m_ptr = 2;
  endtask

  task automatic test_contention();
    rst_n = 1'b0;
    bus.req = 4'b0000;
    step();
    rst_n = 1'b1;
    bus.req = 4'b1111;
    bus.we = 4'b1111;
    bus.wdata = 32'h0403_0201;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.gnt !== oh(i % N)) begin failures++; $display("FAIL cont_gnt%0d got=%b exp=%b", i, bus.gnt, oh(i % N)); end
      step();
      checks++; if (bus.ack !== oh(i % N)) begin failures++; $display("FAIL cont_ack%0d got=%b exp=%b", i, bus.ack, oh(i % N)); end
      checks++; if (bus.reg_q !== 8'((i % N) + 1)) begin failures++; $display("FAIL cont_reg%0d got=%h exp=%h", i, bus.reg_q, 8'((i % N) + 1)); end
      step();
      checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin failures++; $display("FAIL cont_idle%0d busy=%b gnt=%b", i, bus.busy, bus.gnt); end
    end
    bus.req = 4'b0000;
    m_ptr = 1; m_reg = 8'h01; m_rdata = 8'h01;
  endtask

  task automatic test_abort();
    bus.req = 4'b1000;
    bus.we = 4'b1000;
    bus.wdata = 32'hFF00_0000;
    step();
    checks++; if (bus.gnt !== 4'b1000) begin failures++; $display("FAIL ab_gnt got=%b exp=1000", bus.gnt); end
    bus.req = 4'b0000;
    step();
    checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL ab_noack ack=%b busy=%b exp 0000/0", bus.ack, bus.busy); end
    checks++; if (bus.reg_q !== m_reg) begin failures++; $display("FAIL ab_reg got=%h exp=%h", bus.reg_q, m_reg); end
    bus.req = 4'b1010;
    bus.we = 4'b0000;
    step();
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL ab_ptr_gnt got=%b exp=0010", bus.gnt); end
    step();
    checks++; if (bus.ack !== 4'b0010 || bus.rdata !== m_reg) begin failures++; $display("FAIL ab_read ack=%b rdata=%h exp 0010/%h", bus.ack, bus.rdata, m_reg); end
    bus.req = 4'b0000;
    step();
    m_ptr = 2; m_rdata = m_reg;
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0001;
    bus.we = 4'b0001;
    bus.wdata = 32'h0000_003C;
    step();
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL rm_gnt got=%b exp=0001", bus.gnt); end
    rst_n = 1'b0;
    step();
    checks++; if (bus.reg_q !== 8'h00) begin failures++; $display("FAIL rm_reg got=%h exp=00", bus.reg_q); end
    checks++; if (bus.gnt !== 4'b0000 || bus.ack !== 4'b0000) begin failures++; $display("FAIL rm_gntack gnt=%b ack=%b exp 0000/0000", bus.gnt, bus.ack); end
    rst_n = 1'b1;
    bus.req = 4'b1111;
    bus.we = 4'b0000;
    step();
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL rm_ptr got=%b exp=0001", bus.gnt); end
    bus.req = 4'b0000;
    step();
    m_ptr = 1; m_reg = 8'h00; m_rdata = 8'h00;
  endtask

  task automatic test_random();
    for (int t = 0; t < 80; t++) begin
      logic [N-1:0] r;
      logic [W-1:0] exp_v;
      int w;
      bit abort;
      r = 4'($urandom_range(1, 15));
      bus.req = r;
      bus.we = 4'($urandom);
      bus.wdata = 32'($urandom);
      w = rr_winner(r, m_ptr);
      step();
      checks++; if (bus.gnt !== oh(w) || bus.ack !== 4'b0000) begin failures++; $display("FAIL rnd_gnt t=%0d gnt=%b ack=%b exp %b/0000", t, bus.gnt, bus.ack, oh(w)); end
      abort = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if (i != w) begin
          bus.req[i] = 1'($urandom);
          bus.we[i] = 1'($urandom);
          bus.wdata[i*W +: W] = 8'($urandom);
        end
      end
      if (abort) bus.req[w] = 1'b0;
      exp_v = bus.we[w] ? bus.wdata[w*W +: W] : m_reg;
      step();
      m_ptr = (w + 1) % N;
      if (abort) begin
        checks++; if (bus.ack !== 4'b0000 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL rnd_abort t=%0d ack=%b gnt=%b busy=%b", t, bus.ack, bus.gnt, bus.busy); end
        checks++; if (bus.reg_q !== m_reg || bus.rdata !== m_rdata) begin failures++; $display("FAIL rnd_abort_data t=%0d reg=%h rdata=%h exp %h/%h", t, bus.reg_q, bus.rdata, m_reg, m_rdata); end
      end else begin
        m_reg = exp_v;
        m_rdata = exp_v;
        checks++; if (bus.ack !== oh(w) || bus.gnt !== 4'b0000) begin failures++; $display("FAIL rnd_ack t=%0d ack=%b gnt=%b exp %b/0000", t, bus.ack, bus.gnt, oh(w)); end
        checks++; if (bus.reg_q !== m_reg || bus.rdata !== m_rdata) begin failures++; $display("FAIL rnd_data t=%0d reg=%h rdata=%h exp %h/%h", t, bus.reg_q, bus.rdata, m_reg, m_rdata); end
        step();
        checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.rdata !== m_rdata) begin failures++; $display("FAIL rnd_hold t=%0d ack=%b busy=%b rdata=%h exp rdata=%h", t, bus.ack, bus.busy, bus.rdata, m_rdata); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_contention();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
